// File: rtl/fifo_mem.sv
// Synchronous single-clock FIFO with registered read data, fill-level flags and fill count.
// Define FIFO_ERROR_EN to build the sticky overflow/underflow error flag; otherwise error is tied to 0.
module fifo_mem #(
    parameter int MEM_SIZE        = 8,
    parameter int WORD_SIZE       = 10,
    parameter int PTR             = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 push,
    input  logic                 pop,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR:0]         fifo_count,
    output logic                 error
);

    localparam logic [PTR:0] LP_MEM_SIZE = (PTR+1)'(MEM_SIZE);
    localparam logic [PTR:0] LP_AF_TH    = (PTR+1)'(ALMOST_FULL_TH);
    localparam logic [PTR:0] LP_AE_TH    = (PTR+1)'(ALMOST_EMPTY_TH);

    logic [WORD_SIZE-1:0] r_mem [MEM_SIZE];
    logic [PTR-1:0]       r_wr_ptr;
    logic [PTR-1:0]       r_rd_ptr;
    logic [PTR:0]         r_count;
    logic [WORD_SIZE-1:0] r_data_out;
    logic                 r_valid_out;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_ok;
    logic                 w_pop_ok;
    logic [PTR:0]         w_count_next;

    // Flags come only from the registered count, never from this cycle's requests.
    assign w_full    = (r_count == LP_MEM_SIZE);
    assign w_empty   = (r_count == '0);

    // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
    assign w_push_ok = push && (!w_full || pop);
    assign w_pop_ok  = pop && !w_empty;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + (PTR+1)'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_next = r_count - (PTR+1)'(1);
        end
    end

    // NOTE: the storage array sits on the async reset because stale words must never survive a reset; this costs a reset net on every cell.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // NOTE: non-blocking assignments let a full-FIFO push/pop read the old word at rd_ptr while the same slot is overwritten.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_valid_out <= w_pop_ok;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr   <= r_rd_ptr + PTR'(1);
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef FIFO_ERROR_EN
    logic r_error;
    logic w_overflow;
    logic w_underflow;

    assign w_overflow  = push && w_full && !pop;
    assign w_underflow = pop && w_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if (w_overflow || w_underflow) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    assign data_out     = r_data_out;
    assign valid_out    = r_valid_out;
    assign fifo_count   = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= LP_AF_TH);
    assign almost_empty = (r_count <= LP_AE_TH);

endmodule

// File: tb/tb_fifo_mem.sv
// Directed self-checking bench for fifo_mem: fill/drain, overflow, pointer wrap,
// simultaneous push/pop at both boundaries, and asynchronous reset mid-burst.
module tb_fifo_mem;

    logic       clk;
    logic       reset;
    logic [9:0] data_in;
    logic       push;
    logic       pop;
    logic [9:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] fifo_count;
    logic       error;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FIFO_ERROR_EN
    localparam logic EXP_ERR_AFTER_FAULT = 1'b1;
`else
    localparam logic EXP_ERR_AFTER_FAULT = 1'b0;
`endif

    fifo_mem dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .push         (push),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_count   (fifo_count),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic step(input logic p, input logic q, input logic [9:0] d);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
    endtask

    task automatic check_flags(input string tag, input int cnt);
        check({tag, "_count"}, 32'(fifo_count), 32'(cnt));
        check({tag, "_full"},  32'(full),         32'(cnt == 8));
        check({tag, "_empty"}, 32'(empty),        32'(cnt == 0));
        check({tag, "_af"},    32'(almost_full),  32'(cnt >= 6));
        check({tag, "_ae"},    32'(almost_empty), 32'(cnt <= 2));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its end, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] wrap_words [6];
        wrap_words = '{10'h155, 10'h156, 10'h157, 10'h158, 10'h159, 10'h15A};

        reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
        #23;
        check_flags("rst", 0);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_dout",  32'(data_out),  0);
        check("rst_err",   32'(error),     0);
        reset = 1'b1;

        // Fill 0x001..0x008
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 10'(i));
            check_flags($sformatf("fill%0d", i), i);
        end

        // Overflow: push while full, no pop
        step(1'b1, 1'b0, 10'h3FF);
        check_flags("ovf", 8);
        check("ovf_err", 32'(error), 32'(EXP_ERR_AFTER_FAULT));

        // Drain: order must be unaffected by the rejected 0x3FF
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, '0);
            check($sformatf("drain%0d_dout", i),  32'(data_out),  32'(i));
            check($sformatf("drain%0d_valid", i), 32'(valid_out), 1);
            check_flags($sformatf("drain%0d", i), 8 - i);
        end
        step(1'b0, 1'b0, '0);
        check("idle_valid", 32'(valid_out), 0);
        check("idle_dout",  32'(data_out),  32'h008);

        // Underflow: pop while empty
        step(1'b0, 1'b1, '0);
        check("udf_valid", 32'(valid_out), 0);
        check("udf_dout",  32'(data_out),  32'h008);
        check_flags("udf", 0);
        check("udf_err", 32'(error), 32'(EXP_ERR_AFTER_FAULT));

        // Pointer wrap: advance pointers by 5, then 6 words straddle the end of memory
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10'h0A1 + 10'(i));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, '0);
            check($sformatf("pre%0d_dout", i), 32'(data_out), 32'h0A1 + 32'(i));
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, wrap_words[i]);
        check_flags("wrapfill", 6);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, '0);
            check($sformatf("wrap%0d_dout", i), 32'(data_out), 32'(wrap_words[i]));
        end
        check_flags("wrapdrain", 0);

        // Simultaneous push/pop while empty: push only
        step(1'b1, 1'b1, 10'h0AA);
        check_flags("sim_empty", 1);
        check("sim_empty_valid", 32'(valid_out), 0);
        check("sim_empty_dout",  32'(data_out),  32'h15A);

        // Fill to full, then simultaneous push/pop while full
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, 10'h0B0 + 10'(i));
        check_flags("refill", 8);
        step(1'b1, 1'b1, 10'h0CC);
        check_flags("sim_full", 8);
        check("sim_full_valid", 32'(valid_out), 1);
        check("sim_full_dout",  32'(data_out),  32'h0AA);
        step(1'b0, 1'b1, '0);
        check("after_sim_dout", 32'(data_out), 32'h0B1);
        check_flags("after_sim", 7);

        // Asynchronous reset between edges while a burst is in flight
        push = 1'b1; data_in = 10'h2AA;
        #3;
        reset = 1'b0;
        #1;
        check_flags("arst", 0);
        check("arst_dout",  32'(data_out),  0);
        check("arst_valid", 32'(valid_out), 0);
        check("arst_err",   32'(error),     0);
        @(posedge clk);
        #1;
        check("arst_hold_count", 32'(fifo_count), 0);
        #2;
        reset = 1'b1;
        push  = 1'b0;
        @(posedge clk);
        #1;
        check_flags("post_rst", 0);
        step(1'b1, 1'b0, 10'h123);
        step(1'b0, 1'b1, '0);
        check("post_rst_dout", 32'(data_out), 32'h123);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_mem.md
FIFO_MEM -- requirements
Module: fifo_mem

Interface
REQ-001 The block SHALL have parameter MEM_SIZE, default 8, FIFO depth in words, always equal to 2**PTR.
REQ-002 The block SHALL have parameter WORD_SIZE, default 10, data width in bits.
REQ-003 The block SHALL have parameter PTR, default 3, pointer width in bits.
REQ-004 The block SHALL have parameter ALMOST_FULL_TH, default 6, fill level at which almost_full asserts.
REQ-005 The block SHALL have parameter ALMOST_EMPTY_TH, default 2, fill level at which almost_empty asserts.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port data_in, input, WORD_SIZE bits, write data.
REQ-009 The block SHALL have port push, input, 1 bit, write request.
REQ-010 The block SHALL have port pop, input, 1 bit, read request.
REQ-011 The block SHALL have port data_out, output, WORD_SIZE bits, registered read data.
REQ-012 The block SHALL have port valid_out, output, 1 bit, data_out holds a newly popped word.
REQ-013 The block SHALL have port full, output, 1 bit, fifo_count equals MEM_SIZE.
REQ-014 The block SHALL have port empty, output, 1 bit, fifo_count equals 0.
REQ-015 The block SHALL have port almost_full, output, 1 bit, fifo_count >= ALMOST_FULL_TH.
REQ-016 The block SHALL have port almost_empty, output, 1 bit, fifo_count <= ALMOST_EMPTY_TH.
REQ-017 The block SHALL have port fifo_count, output, PTR+1 bits, words currently stored.
REQ-018 The block SHALL have port error, output, 1 bit, overflow/underflow indicator (see Configuration).

Function
REQ-019 The block SHALL keep internal wr_ptr and rd_ptr, PTR bits each, incrementing modulo MEM_SIZE (wrap from MEM_SIZE-1 to 0).
REQ-020 The block SHALL accept a push when push=1 and (full=0 or pop=1): write data_in at wr_ptr, advance wr_ptr.
REQ-021 The block SHALL accept a pop when pop=1 and empty=0: register mem[rd_ptr] into data_out, advance rd_ptr, assert valid_out for exactly that following cycle.
REQ-022 The block SHALL give a read latency of one cycle: word popped at edge N is visible on data_out after edge N.
REQ-023 The block SHALL hold data_out unchanged and drive valid_out=0 on any cycle with no accepted pop.
REQ-024 The block SHALL update fifo_count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-025 The block SHALL, when full and push=pop=1, accept both; fifo_count stays MEM_SIZE; no overflow.
REQ-026 The block SHALL, when empty and push=pop=1, accept the push only; the pop is an underflow; fifo_count becomes 1.
REQ-027 The block SHALL ignore push when full and pop=0 (overflow): memory, wr_ptr, fifo_count unchanged.
REQ-028 The block SHALL ignore pop when empty (underflow): rd_ptr, data_out unchanged, valid_out=0.
REQ-029 The block SHALL derive full, empty, almost_full, almost_empty combinationally from registered fifo_count only.

Reset
REQ-030 The block SHALL, while reset=0, immediately clear wr_ptr, rd_ptr, fifo_count, data_out, valid_out, error and all memory words to 0.
REQ-031 The block SHALL present after reset: empty=1, almost_empty=1, full=0, almost_full=0; a reset mid-burst discards all stored words.
REQ-032 The block SHALL ignore push/pop on the first rising edge coinciding with reset deassertion only if reset is still low at that edge.

Configuration
REQ-033 The block SHALL, with macro FIFO_ERROR_EN defined, set error=1 on the edge after any overflow or underflow and hold it (sticky) until reset.
REQ-034 The block SHALL, without FIFO_ERROR_EN, tie error to 0 and contain no error logic; all other behaviour identical.

Verification
REQ-035 Bench SHALL: reset, push 0x001..0x008 on 8 cycles -> fifo_count=8, full=1, almost_full=1 from count 6, empty=0.
REQ-036 Bench SHALL: from full, pop 8 cycles -> data_out 0x001..0x008 one cycle after each pop, valid_out=1 each, then empty=1, almost_empty=1.
REQ-037 Bench SHALL: push 0x3FF when full, pop=0 -> count stays 8, next pop order unchanged; error=1 only with FIFO_ERROR_EN.
REQ-038 Bench SHALL: push 5 words, pop 5, push 0x155..0x15A (6 words) -> pointers wrap, pops return 0x155..0x15A in order.
REQ-039 Bench SHALL: simultaneous push/pop when full and when empty -> count 8 stays 8; count 0 becomes 1, valid_out=0.
REQ-040 Bench SHALL: assert reset low mid-burst between edges -> outputs clear immediately, count=0, error=0.
